// File: rtl/receiver_transmitter.sv
// 8N1 UART: independent receiver and transmitter sharing only clk and reset.
// The receiver double-flops rx, qualifies the start bit at its centre and samples
// each data bit and the stop bit at their centres. The transmitter latches din at
// frame start and drives a registered tx line.
module receiver_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       res,
  input  logic       rx,
  output logic       take,
  output logic [7:0] dout,
  input  logic       drl,
  input  logic [7:0] din,
  output logic       load,
  output logic       tx
);

  // Counter runs 0..CLKS_PER_BIT-1 inside one bit, so clog2 bits never wrap.
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LOAD_CNT  = CNT_W'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  logic             r_rx_meta;
  logic             r_rx_sync;
  rx_state_e        r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             r_rx_armed;
  logic             r_take;
  logic [7:0]       r_dout;

  rx_state_e        w_rx_state_nxt;
  logic [CNT_W-1:0] w_rx_cnt_nxt;
  logic [2:0]       w_rx_bit_nxt;
  logic [7:0]       w_rx_shift_nxt;
  logic             w_rx_armed_nxt;
  logic             w_take_nxt;
  logic [7:0]       w_dout_nxt;

  // Two-flop synchronizer; resets low so a line held low across reset is not
  // mistaken for idle.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_rx_meta <= 1'b0;
      r_rx_sync <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_rx_state <= R_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_armed <= 1'b0;
      r_take     <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_armed <= w_rx_armed_nxt;
      r_take     <= w_take_nxt;
      r_dout     <= w_dout_nxt;
    end
  end

  // Receiver next state: a start is only accepted after the line was seen high
  // (armed), which drops frames already in progress at reset or after a break.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_armed_nxt = r_rx_armed;
    w_take_nxt     = 1'b0;
    w_dout_nxt     = r_dout;
    case (r_rx_state)
      R_IDLE: begin
        w_rx_cnt_nxt = '0;
        w_rx_bit_nxt = '0;
        if (r_rx_armed && !r_rx_sync) begin
          w_rx_state_nxt = R_START;
          w_rx_armed_nxt = 1'b0;
        end else if (r_rx_sync) begin
          w_rx_armed_nxt = 1'b1;
        end
      end
      R_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = r_rx_sync ? R_IDLE : R_DATA;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      R_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          w_rx_bit_nxt   = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) begin
            w_rx_state_nxt = R_STOP;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      R_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = R_IDLE;
          if (r_rx_sync) begin
            w_take_nxt = 1'b1;
            w_dout_nxt = r_rx_shift;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_rx_state_nxt = R_IDLE;
        w_rx_cnt_nxt   = '0;
      end
    endcase
  end

  assign take = r_take;
  assign dout = r_dout;

  // ---------------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------------
  tx_state_e        r_tx_state;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [2:0]       r_tx_bit;
  logic [7:0]       r_tx_shift;
  logic             r_tx;
  logic             r_load;

  tx_state_e        w_tx_state_nxt;
  logic [CNT_W-1:0] w_tx_cnt_nxt;
  logic [2:0]       w_tx_bit_nxt;
  logic [7:0]       w_tx_shift_nxt;
  logic             w_tx_nxt;
  logic             w_load_nxt;

  // Transmitter state and datapath registers; tx idles high in reset.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_tx_state <= T_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
      r_load     <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_load     <= w_load_nxt;
    end
  end

  // Transmitter next state: tx is computed one cycle ahead so the line comes
  // straight from a flop; load is raised one count early to land on the last
  // stop-bit cycle.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_nxt       = r_tx;
    w_load_nxt     = 1'b0;
    case (r_tx_state)
      T_IDLE: begin
        w_tx_cnt_nxt = '0;
        w_tx_bit_nxt = '0;
        w_tx_nxt     = 1'b1;
        if (drl) begin
          w_tx_shift_nxt = din;
          w_tx_state_nxt = T_START;
          w_tx_nxt       = 1'b0;
        end
      end
      T_START: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = T_DATA;
          w_tx_nxt       = r_tx_shift[0];
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      T_DATA: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nxt = T_STOP;
            w_tx_nxt       = 1'b1;
          end else begin
            w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
            w_tx_nxt       = r_tx_shift[1];
            w_tx_bit_nxt   = r_tx_bit + 3'd1;
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      T_STOP: begin
        w_load_nxt = (r_tx_cnt == LOAD_CNT);
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = T_IDLE;
          w_tx_nxt       = 1'b1;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_tx_state_nxt = T_IDLE;
        w_tx_cnt_nxt   = '0;
        w_tx_nxt       = 1'b1;
      end
    endcase
  end

  assign tx   = r_tx;
  assign load = r_load;

endmodule

// File: tb/tb_receiver_transmitter.sv
// Bench for receiver_transmitter: frame-level model of both serial paths with a
// per-cycle compare process, plus literal checks on a few hand-worked cases.
`timescale 1ns/1ps
module tb_receiver_transmitter;

  localparam int unsigned C        = 16;
  localparam int unsigned FRAME    = 10 * C;
  localparam int unsigned TAKE_LAT = (19 * C) / 2;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       rx_drv;
  logic       lb;
  logic       drl;
  logic [7:0] din;
  logic       take;
  logic [7:0] dout;
  logic       load;
  logic       tx;
  logic       rx_w;

  assign rx_w = lb ? tx : rx_drv;

  receiver_transmitter #(.CLKS_PER_BIT(C)) dut (
    .clk  (clk),
    .res  (res),
    .rx   (rx_w),
    .take (take),
    .dout (dout),
    .drl  (drl),
    .din  (din),
    .load (load),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         n0;
  } rxexp_t;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         busy  = 0;
  int         loads = 0;
  int         takes = 0;
  logic [7:0] last_dout = 8'h00;
  rxexp_t     rxq[$];
  logic [1:0] txq[$];
  logic [9:0] m_fr;
  logic [1:0] m_e;
  rxexp_t     m_x;
  int         m_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter model: a frame starts on any edge where the line is free and drl
  // is high; its whole waveform is queued as {load, tx} per cycle.
  always @(posedge clk or negedge res) begin
    if (!res) begin
      busy = 0;
      txq.delete();
      rxq.delete();
    end else begin
      cyc++;
      if (busy > 0) begin
        busy--;
      end else if (drl === 1'b1) begin
        m_fr = {1'b1, din, 1'b0};
        for (int j = 0; j < int'(FRAME); j++)
          txq.push_back({(j == int'(FRAME) - 1), m_fr[j / int'(C)]});
        busy = FRAME;
        if (lb) rxq.push_back('{din, cyc});
      end
    end
  end

  // Per-cycle compare of both paths against the model.
  always @(negedge clk) begin
    if (!res) begin
      chk("rst_tx",   32'(tx),   32'(1));
      chk("rst_load", 32'(load), 32'(0));
      chk("rst_take", 32'(take), 32'(0));
      chk("rst_dout", 32'(dout), 32'(0));
      last_dout = 8'h00;
    end else begin
      m_e = (txq.size() > 0) ? txq.pop_front() : 2'b01;
      chk("tx",   32'(tx),   32'(m_e[0]));
      chk("load", 32'(load), 32'(m_e[1]));
      if (load === 1'b1) loads++;
      if (take === 1'b1) begin
        takes++;
        if (rxq.size() == 0) begin
          chk("take_unexpected", 32'(take), 32'(0));
        end else begin
          m_x   = rxq.pop_front();
          m_lat = cyc - m_x.n0;
          chk("dout", 32'(dout), 32'(m_x.b));
          chk("take_latency_ok",
              32'((m_lat >= int'(TAKE_LAT) - 2) && (m_lat <= int'(TAKE_LAT) + 8)), 32'(1));
          last_dout = m_x.b;
        end
      end else begin
        chk("dout_hold", 32'(dout), 32'(last_dout));
        if (rxq.size() > 0 && (cyc - rxq[0].n0) > int'(TAKE_LAT) + 8) begin
          chk("take_missing", 32'(take), 32'(1));
          void'(rxq.pop_front());
        end
      end
    end
  end

  // Drive one rx frame starting at the next falling clock edge.
  task automatic send_rx(input logic [7:0] b, input logic stop, input bit expect_it);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(negedge clk);
    if (expect_it) rxq.push_back('{b, cyc});
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      repeat (C) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  logic [9:0] lit;
  logic [7:0] rb;
  logic       rs;
  logic [7:0] lb_bytes [3];
  int         l0, t0, c1, c4, idx, seen;

  initial begin
    rx_drv = 1'b1;
    lb     = 1'b0;
    drl    = 1'b0;
    din    = 8'h00;
    #1 res = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 res = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame of 8'hF4 with literal bit-centre checks.
    l0  = loads;
    lit = {1'b1, 8'hF4, 1'b0};
    drl = 1'b1;
    din = 8'hF4;
    @(negedge clk);
    drl = 1'b0;
    for (int j = 0; j < int'(FRAME); j++) begin
      if (j > 0) @(negedge clk);
      if (j % int'(C) == int'(C) / 2) chk("lit_tx_bit", 32'(tx), 32'(lit[j / int'(C)]));
      if (j == int'(FRAME) - 1) chk("lit_load_end", 32'(load), 32'(1));
    end
    repeat (20) @(negedge clk);
    chk("lit_tx_idle", 32'(tx), 32'(1));
    chk("lit_one_load", 32'(loads - l0), 32'(1));

    // Receive 8'hF0.
    t0 = takes;
    send_rx(8'hF0, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("lit_dout_F0", 32'(dout), 32'(8'hF0));
    chk("lit_one_take", 32'(takes - t0), 32'(1));

    // Continuous transmit with din advanced on each load.
    l0  = loads;
    idx = 0;
    c1  = 0;
    c4  = 0;
    din = 8'h01;
    drl = 1'b1;
    for (int k = 0; k < 6 * int'(FRAME) && idx < 4; k++) begin
      @(negedge clk);
      if (load === 1'b1) begin
        idx++;
        case (idx)
          1: begin din = 8'h02; c1 = cyc; end
          2: din = 8'h03;
          3: din = 8'hFF;
          default: begin drl = 1'b0; c4 = cyc; end
        endcase
      end
    end
    drl = 1'b0;
    repeat (2 * C) @(negedge clk);
    chk("lit_four_loads", 32'(loads - l0), 32'(4));
    chk("lit_frame_spacing", 32'(c4 - c1), 32'(3 * (FRAME + 1)));

    // Start glitch and framing error are both dropped; a good frame follows.
    t0 = takes;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * C) @(negedge clk);
    send_rx(8'h5A, 1'b0, 1'b0);
    repeat (3 * C) @(negedge clk);
    chk("lit_no_take_bad", 32'(takes - t0), 32'(0));
    chk("lit_dout_kept", 32'(dout), 32'(8'hF0));
    send_rx(8'h96, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("lit_dout_96", 32'(dout), 32'(8'h96));

    // Loopback of tx into rx.
    lb = 1'b1;
    lb_bytes[0] = 8'h00;
    lb_bytes[1] = 8'hA5;
    lb_bytes[2] = 8'hFF;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      din  = lb_bytes[i];
      drl  = 1'b1;
      seen = 0;
      @(negedge clk);
      drl = 1'b0;
      for (int k = 0; k < int'(FRAME) + 10 && seen == 0; k++) begin
        @(negedge clk);
        if (load === 1'b1) seen = 1;
      end
      chk("lit_lb_load_seen", 32'(seen), 32'(1));
      repeat (4) @(negedge clk);
      chk("lit_lb_dout", 32'(dout), 32'(lb_bytes[i]));
    end
    lb = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of both frames, then a clean transfer each way.
    l0 = loads;
    t0 = takes;
    fork
      begin
        din = 8'h5A;
        drl = 1'b1;
        @(negedge clk);
        drl = 1'b0;
      end
      send_rx(8'h00, 1'b1, 1'b1);
      begin
        repeat (3 * C + 5) @(posedge clk);
        #3 res = 1'b0;
        #1;
        chk("lit_async_tx", 32'(tx), 32'(1));
        chk("lit_async_dout", 32'(dout), 32'(0));
        repeat (5) @(posedge clk);
        #3 res = 1'b1;
      end
    join
    repeat (2 * C) @(negedge clk);
    fork
      send_rx(8'h3C, 1'b1, 1'b1);
      begin
        din = 8'hC3;
        drl = 1'b1;
        @(negedge clk);
        drl = 1'b0;
      end
    join
    repeat (2 * C) @(negedge clk);
    chk("lit_rst_dout", 32'(dout), 32'(8'h3C));
    chk("lit_rst_loads", 32'(loads - l0), 32'(1));
    chk("lit_rst_takes", 32'(takes - t0), 32'(1));

    // Randomized full-duplex traffic.
    fork
      begin
        for (int k = 0; k < 3000; k++) begin
          @(negedge clk);
          if ($urandom_range(0, 7) == 0) drl = ~drl;
          din = 8'($urandom);
        end
        drl = 1'b0;
      end
      begin
        for (int k = 0; k < 14; k++) begin
          rb = 8'($urandom);
          rs = ($urandom_range(0, 3) != 0);
          send_rx(rb, rs, rs);
          repeat ($urandom_range(0, 20)) @(negedge clk);
        end
      end
    join
    repeat (FRAME + 2 * C) @(negedge clk);
    chk("txq_drained", 32'(txq.size()), 32'(0));
    chk("rxq_drained", 32'(rxq.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/receiver_transmitter.md
RECEIVER_TRANSMITTER -- requirements
Module: receiver_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 4.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 res  input  1  asynchronous active-low reset.
REQ-004 rx  input  1  serial line in, idle high, asynchronous to clk.
REQ-005 take  output  1  one-cycle pulse: new received byte valid on dout.
REQ-006 dout  output  8  last correctly received byte.
REQ-007 drl  input  1  transmit request level; held high to keep sending frames.
REQ-008 din  input  8  byte to transmit, latched at frame start.
REQ-009 load  output  1  one-cycle pulse: current frame finished, din may be updated.
REQ-010 tx  output  1  serial line out, idle high.

Function
REQ-011 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, each CLKS_PER_BIT cycles.
REQ-012 Receive and transmit paths SHALL be fully independent (full duplex, no shared state).
REQ-013 rx SHALL pass a 2-flop synchronizer before any use.
REQ-014 Receiver states: R_IDLE, R_START, R_DATA, R_STOP.
REQ-015 R_IDLE: synchronized rx = 0 -> R_START, counter cleared.
REQ-016 R_START: at CLKS_PER_BIT/2 cycles, rx still 0 -> R_DATA; rx = 1 -> R_IDLE (glitch rejected, no take).
REQ-017 R_DATA: sample rx every CLKS_PER_BIT cycles (bit centre) into bit index 0..7; after bit 7 -> R_STOP.
REQ-018 R_STOP: sample at stop-bit centre; 1 -> dout updated with assembled byte and take = 1 for exactly that cycle; 0 (framing error) -> byte discarded, dout unchanged, no take; both -> R_IDLE.
REQ-019 Receiver SHALL accept back-to-back frames: a falling edge after stop-bit centre starts the next frame.
REQ-020 dout SHALL hold its value between takes.
REQ-021 Transmitter states: T_IDLE, T_START, T_DATA, T_STOP.
REQ-022 T_IDLE: tx = 1; drl = 1 -> din latched into internal shift register, -> T_START.
REQ-023 T_START drives 0, T_DATA drives bits 0..7, T_STOP drives 1, each exactly CLKS_PER_BIT cycles; tx SHALL be registered (glitch-free).
REQ-024 At the last cycle of the stop bit: load = 1 for exactly one cycle, -> T_IDLE.
REQ-025 If drl is still 1 in the cycle after load, the next frame SHALL start with the din present then, giving exactly one idle-high cycle between frames.
REQ-026 din and drl changes during a frame SHALL NOT affect the frame in flight; dropping drl mid-frame SHALL complete the current frame, including its load pulse.
REQ-027 Bit and cycle counters SHALL be wide enough for CLKS_PER_BIT and SHALL NOT wrap within a bit.

Reset
REQ-028 While res = 0: tx = 1, load = 0, take = 0, dout = 8'h00, both FSMs idle, counters and shift registers cleared.
REQ-029 Reset mid-frame SHALL abort both paths immediately; the aborted TX frame produces no load, the aborted RX frame produces no take.
REQ-030 After res deasserts, a byte on rx already in progress SHALL be ignored until rx is seen idle-high then falling.

Verification (CLKS_PER_BIT = 16)
REQ-031 drl = 1 one cycle, din = 8'hF4 -> tx: 0, 0,0,1,0,1,1,1,1, 1, 16 cycles each; one load pulse at stop end; tx stays 1.
REQ-032 rx driven with frame 8'hF0 -> take pulses once about 8 cycles into stop bit, dout = 8'hF0.
REQ-033 drl held high; on each load, din advances 8'h01, 8'h02, 8'h03, 8'hFF -> four contiguous frames, one idle cycle between, four load pulses.
REQ-034 rx low pulse of 4 cycles -> no take, dout unchanged; rx frame with stop bit 0 -> no take.
REQ-035 tx loopback to rx, bytes 8'h00, 8'hA5, 8'hFF -> each received with take, dout matching.
REQ-036 res asserted during T_DATA and R_DATA -> tx = 1 asynchronously, no load, no take; the next full frame after release transfers correctly.
